// File: rtl/scope_trace_renderer.sv
// Oscilloscope trace renderer: captures one triggered window of audio samples into a
// double-buffered line store and draws it as a connected trace over the pixel timing.
module scope_trace_renderer #(
   parameter int unsigned H_RES        = 800,
   parameter int unsigned V_RES        = 600,
   parameter int unsigned SAMPLE_W     = 24,
   parameter int unsigned Y_SHIFT      = 14,
   parameter int unsigned TRIG_TIMEOUT = 4096,
   parameter logic [23:0] TRACE_RGB    = 24'h00FF00,
   parameter logic [23:0] AXIS_RGB     = 24'h404040,
   parameter logic [23:0] BG_RGB       = 24'h000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   input  logic [9:0]          pixel_x,
   input  logic [9:0]          pixel_y,
   input  logic                hsync,
   input  logic                vsync,
   input  logic                active,
   output logic [23:0]         rgb,
   output logic                hsync_out,
   output logic                vsync_out,
   output logic                active_out,
   output logic                frame_swap
);
   localparam int unsigned IDX_W = $clog2(H_RES);
   localparam int unsigned TMO_W = $clog2(TRIG_TIMEOUT + 1);
   localparam int unsigned YW    = 10;
   localparam logic signed [SAMPLE_W-1:0] LIM_P = SAMPLE_W'(V_RES / 2 - 1);
   localparam logic signed [SAMPLE_W-1:0] LIM_N = -LIM_P;

   typedef enum logic [1:0] {ST_ARMED, ST_CAPTURE, ST_DONE} state_e;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic                 prev_neg_q, prev_neg_d;
   logic                 disp_sel_q, disp_sel_d;
   logic                 disp_valid_q, disp_valid_d;
   logic                 wr_en_c, swap_c, vs_rise_c, rd_en_c;

   logic [YW-1:0]        mem_q [2][H_RES];
   logic [YW-1:0]        cur_q, prev_q;
   logic                 x0_q, act_d1_q, hs_d1_q, vs_d1_q;
   logic [YW-1:0]        y_d1_q;
   logic [23:0]          rgb_q, rgb_d;
   logic                 hs_d2_q, vs_d2_q, act_d2_q, frame_swap_q;

   logic signed [SAMPLE_W-1:0] shifted_c, clamped_c;
   logic [YW-1:0]        y_c;

   // Sample to screen row: scale, clamp to the visible half-height, flip about the axis.
   always_comb begin
      shifted_c = $signed(sample_in) >>> Y_SHIFT;
      if (shifted_c > LIM_P)      clamped_c = LIM_P;
      else if (shifted_c < LIM_N) clamped_c = LIM_N;
      else                        clamped_c = shifted_c;
      y_c = YW'(V_RES / 2) - YW'(clamped_c);
   end

   assign vs_rise_c = vsync & ~vs_d1_q;

   // Capture FSM: only advances on sample_valid, except the swap in DONE.
   always_comb begin
      state_d      = state_q;
      wr_idx_d     = wr_idx_q;
      tmo_d        = tmo_q;
      prev_neg_d   = prev_neg_q;
      disp_sel_d   = disp_sel_q;
      disp_valid_d = disp_valid_q;
      wr_en_c      = 1'b0;
      swap_c       = 1'b0;
      case (state_q)
         ST_ARMED: begin
            if (sample_valid) begin
               prev_neg_d = sample_in[SAMPLE_W-1];
               if ((prev_neg_q && !sample_in[SAMPLE_W-1]) || (tmo_q == TMO_W'(TRIG_TIMEOUT))) begin
                  wr_en_c    = 1'b1;
                  wr_idx_d   = IDX_W'(1);
                  tmo_d      = '0;
                  prev_neg_d = 1'b0;
                  state_d    = ST_CAPTURE;
               end else begin
                  tmo_d = tmo_q + TMO_W'(1);
               end
            end
         end
         ST_CAPTURE: begin
            if (sample_valid) begin
               wr_en_c = 1'b1;
               if (wr_idx_q == IDX_W'(H_RES - 1)) begin
                  wr_idx_d = '0;
                  state_d  = ST_DONE;
               end else begin
                  wr_idx_d = wr_idx_q + IDX_W'(1);
               end
            end
         end
         ST_DONE: begin
            if (vs_rise_c) begin
               swap_c       = 1'b1;
               disp_sel_d   = ~disp_sel_q;
               disp_valid_d = 1'b1;
               state_d      = ST_ARMED;
               wr_idx_d     = '0;
               tmo_d        = '0;
               prev_neg_d   = 1'b0;
               // A sample in the swap cycle is judged as ARMED with prev = 0: it cannot trigger.
               if (sample_valid) begin
                  prev_neg_d = sample_in[SAMPLE_W-1];
                  tmo_d      = TMO_W'(1);
               end
            end
         end
         default: state_d = ST_ARMED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_ARMED;
         wr_idx_q     <= '0;
         tmo_q        <= '0;
         prev_neg_q   <= 1'b0;
         disp_sel_q   <= 1'b0;
         disp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_idx_q     <= wr_idx_d;
         tmo_q        <= tmo_d;
         prev_neg_q   <= prev_neg_d;
         disp_sel_q   <= disp_sel_d;
         disp_valid_q <= disp_valid_d;
      end
   end

   assign rd_en_c = active && (pixel_x < 10'(H_RES));

   // Line store: write back buffer, read display buffer; prev_q trails cur_q by one column.
   always_ff @(posedge clk) begin
      if (wr_en_c) mem_q[~disp_sel_q][wr_idx_q] <= y_c;
      if (rd_en_c) begin
         cur_q  <= mem_q[disp_sel_q][pixel_x];
         prev_q <= cur_q;
      end
   end

   // Stage 2: vertical fill between adjacent column rows joins the trace.
   always_comb begin
      logic [YW-1:0] p, lo, hi;
      logic          lit;
      p   = x0_q ? cur_q : prev_q;
      lo  = (p < cur_q) ? p : cur_q;
      hi  = (p < cur_q) ? cur_q : p;
      lit = disp_valid_q && (y_d1_q >= lo) && (y_d1_q <= hi);
      if (!act_d1_q)                      rgb_d = 24'h000000;
      else if (lit)                       rgb_d = TRACE_RGB;
      else if (y_d1_q == YW'(V_RES / 2))  rgb_d = AXIS_RGB;
      else                                rgb_d = BG_RGB;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         x0_q         <= 1'b0;
         y_d1_q       <= '0;
         act_d1_q     <= 1'b0;
         hs_d1_q      <= 1'b0;
         vs_d1_q      <= 1'b0;
         rgb_q        <= '0;
         hs_d2_q      <= 1'b0;
         vs_d2_q      <= 1'b0;
         act_d2_q     <= 1'b0;
         frame_swap_q <= 1'b0;
      end else begin
         x0_q         <= (pixel_x == 10'd0);
         y_d1_q       <= pixel_y;
         act_d1_q     <= active;
         hs_d1_q      <= hsync;
         vs_d1_q      <= vsync;
         rgb_q        <= rgb_d;
         hs_d2_q      <= hs_d1_q;
         vs_d2_q      <= vs_d1_q;
         act_d2_q     <= act_d1_q;
         frame_swap_q <= swap_c;
      end
   end

   assign rgb        = rgb_q;
   assign hsync_out  = hs_d2_q;
   assign vsync_out  = vs_d2_q;
   assign active_out = act_d2_q;
   assign frame_swap = frame_swap_q;
endmodule

// File: tb/tb_scope_trace_renderer.sv
// Directed bench for scope_trace_renderer: pixels are probed individually rather than
// by scanning whole frames, with expected colours worked out by hand.
module tb_scope_trace_renderer;
   localparam logic [23:0] TR = 24'h00FF00;
   localparam logic [23:0] AX = 24'h404040;
   localparam logic [23:0] BG = 24'h000000;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] sample_in;
   logic        sample_valid;
   logic [9:0]  pixel_x, pixel_y;
   logic        hsync, vsync, active;
   logic [23:0] rgb;
   logic        hsync_out, vsync_out, active_out, frame_swap;

   int checks   = 0;
   int failures = 0;

   scope_trace_renderer dut (
      .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .hsync(hsync), .vsync(vsync), .active(active),
      .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out), .active_out(active_out),
      .frame_swap(frame_swap)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [23:0] v);
      sample_in    = v;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic send_n(input logic [23:0] v, input int n);
      for (int i = 0; i < n; i++) send(v);
   endtask

   task automatic vs_pulse(output logic fs);
      vsync = 1'b1;
      tick();
      fs    = frame_swap;
      vsync = 1'b0;
      tick();
   endtask

   // Drive column x-1 then x on row y so the fill sees the real previous column.
   task automatic probe(input int x, input int y, input logic act, output logic [23:0] c);
      pixel_y = 10'(y);
      active  = act;
      pixel_x = (x > 0) ? 10'(x - 1) : 10'(0);
      tick();
      pixel_x = 10'(x);
      tick();
      active  = 1'b0;
      tick();
      c = rgb;
   endtask

   task automatic test_reset();
      logic [23:0] c;
      int px[4] = '{10, 10, 10, 0};
      int py[4] = '{300, 298, 299, 300};
      logic [23:0] ex[4] = '{AX, BG, BG, AX};
      rst = 1'b0; hsync = 1'b1; vsync = 1'b1; active = 1'b1;
      pixel_x = 10'd0; pixel_y = 10'd0;
      repeat (4) tick();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         logic [2:0] exp_o;
         exp_o = (k == 2) ? 3'b111 : 3'b000;
         checks++;
         if ({hsync_out, vsync_out, active_out} !== exp_o) begin
            failures++;
            $display("FAIL reset_out k=%0d got %b exp %b", k, {hsync_out, vsync_out, active_out}, exp_o);
         end
         tick();
      end
      hsync = 1'b0; vsync = 1'b0;
      tick(); tick();
      for (int i = 0; i < 4; i++) begin
         probe(px[i], py[i], 1'b1, c);
         checks++;
         if (c !== ex[i]) begin
            failures++;
            $display("FAIL reset_rgb (%0d,%0d) got %h exp %h", px[i], py[i], c, ex[i]);
         end
      end
   endtask

   task automatic test_trigger();
      logic [23:0] c;
      logic        fs;
      int px[8] = '{10, 10, 10, 1, 1, 0, 0, 799};
      int py[8] = '{298, 300, 297, 299, 301, 300, 299, 298};
      logic [23:0] ex[8] = '{TR, AX, BG, TR, BG, TR, BG, TR};
      send(-24'sd5);
      send(24'd3);
      send_n(24'h008000, 799);
      probe(10, 298, 1'b1, c);
      checks++;
      if (c !== BG) begin failures++; $display("FAIL trig_preswap got %h exp %h", c, BG); end
      vs_pulse(fs);
      checks++;
      if (fs !== 1'b1) begin failures++; $display("FAIL trig_swap got %b exp 1", fs); end
      checks++;
      if (frame_swap !== 1'b0) begin failures++; $display("FAIL trig_swap_width got %b exp 0", frame_swap); end
      for (int i = 0; i < 8; i++) begin
         probe(px[i], py[i], 1'b1, c);
         checks++;
         if (c !== ex[i]) begin
            failures++;
            $display("FAIL trig_rgb (%0d,%0d) got %h exp %h", px[i], py[i], c, ex[i]);
         end
      end
      probe(10, 298, 1'b0, c);
      checks++;
      if (c !== 24'h0) begin failures++; $display("FAIL trig_blank got %h exp 000000", c); end
   endtask

   task automatic test_auto_early();
      logic [23:0] c;
      logic        fs;
      int px[7] = '{0, 10, 799, 10, 0, 10, 10};
      int py[7] = '{301, 301, 301, 298, 302, 300, 302};
      logic [23:0] ex[7] = '{TR, TR, TR, BG, BG, AX, BG};
      // 4096th armed sample is distinct so an early forced capture would show at row 302.
      send_n(-24'sd1000, 4095);
      send(-24'sd20000);
      send_n(-24'sd1000, 400);
      vs_pulse(fs);
      checks++;
      if (fs !== 1'b0) begin failures++; $display("FAIL early_noswap got %b exp 0", fs); end
      probe(10, 298, 1'b1, c);
      checks++;
      if (c !== TR) begin failures++; $display("FAIL early_kept got %h exp %h", c, TR); end
      probe(10, 301, 1'b1, c);
      checks++;
      if (c !== BG) begin failures++; $display("FAIL early_nonew got %h exp %h", c, BG); end
      send_n(-24'sd1000, 400);
      send_n(24'h7FFFFF, 3);
      vs_pulse(fs);
      checks++;
      if (fs !== 1'b1) begin failures++; $display("FAIL auto_swap got %b exp 1", fs); end
      for (int i = 0; i < 7; i++) begin
         probe(px[i], py[i], 1'b1, c);
         checks++;
         if (c !== ex[i]) begin
            failures++;
            $display("FAIL auto_rgb (%0d,%0d) got %h exp %h", px[i], py[i], c, ex[i]);
         end
      end
   endtask

   task automatic test_clamp_fill();
      logic [23:0] c;
      logic        fs;
      int px[9] = '{5, 5, 5, 5, 2, 1, 1, 799, 5};
      int py[9] = '{0, 1, 599, 300, 599, 300, 301, 1, 598};
      logic [23:0] ex[9] = '{BG, TR, TR, TR, TR, TR, BG, TR, TR};
      send(-24'sd5);
      send(24'd3);
      for (int i = 0; i < 799; i++) send((i % 2 == 0) ? 24'h7FFFFF : 24'h800000);
      vs_pulse(fs);
      checks++;
      if (fs !== 1'b1) begin failures++; $display("FAIL clamp_swap got %b exp 1", fs); end
      for (int i = 0; i < 9; i++) begin
         probe(px[i], py[i], 1'b1, c);
         checks++;
         if (c !== ex[i]) begin
            failures++;
            $display("FAIL clamp_rgb (%0d,%0d) got %h exp %h", px[i], py[i], c, ex[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [23:0] c;
      logic        fs;
      logic        h_prev, v_prev, a_prev, h, v, a;
      int px[5] = '{10, 10, 0, 10, 1};
      int py[5] = '{302, 298, 300, 300, 301};
      logic [23:0] ex[5] = '{TR, BG, TR, AX, TR};
      send(-24'sd5);
      send(24'd3);
      send_n(24'h008000, 199);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      probe(5, 298, 1'b1, c);
      checks++;
      if (c !== BG) begin failures++; $display("FAIL mid_notrace got %h exp %h", c, BG); end
      probe(5, 300, 1'b1, c);
      checks++;
      if (c !== AX) begin failures++; $display("FAIL mid_axis got %h exp %h", c, AX); end
      vs_pulse(fs);
      checks++;
      if (fs !== 1'b0) begin failures++; $display("FAIL mid_noswap got %b exp 0", fs); end
      send(-24'sd5);
      send(24'd3);
      send_n(24'hFF8000, 799);
      vs_pulse(fs);
      checks++;
      if (fs !== 1'b1) begin failures++; $display("FAIL mid_swap got %b exp 1", fs); end
      for (int i = 0; i < 5; i++) begin
         probe(px[i], py[i], 1'b1, c);
         checks++;
         if (c !== ex[i]) begin
            failures++;
            $display("FAIL mid_rgb (%0d,%0d) got %h exp %h", px[i], py[i], c, ex[i]);
         end
      end
      // Sync delay: after each edge the outputs must show what was driven two edges back.
      h_prev = hsync; v_prev = vsync; a_prev = active;
      for (int i = 0; i < 24; i++) begin
         h = 1'($urandom_range(0, 1));
         v = 1'($urandom_range(0, 1));
         a = 1'($urandom_range(0, 1));
         hsync = h; vsync = v; active = a;
         tick();
         if (i > 0) begin
            checks++;
            if ({hsync_out, vsync_out, active_out} !== {h_prev, v_prev, a_prev}) begin
               failures++;
               $display("FAIL sync_delay i=%0d got %b exp %b", i,
                        {hsync_out, vsync_out, active_out}, {h_prev, v_prev, a_prev});
            end
         end
         h_prev = h; v_prev = v; a_prev = a;
      end
   endtask

   initial begin
      rst = 1'b0; sample_in = '0; sample_valid = 1'b0;
      pixel_x = '0; pixel_y = '0; hsync = 1'b0; vsync = 1'b0; active = 1'b0;
      test_reset();
      test_trigger();
      test_auto_early();
      test_clamp_fill();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
